// File: rtl/mriscv_lsu.sv
// Load-store unit: sequences one data-memory access per LOAD/STORE and stalls the core until it completes.
// Optional WAIT timeout abort enabled by defining MRISCV_LSU_TIMEOUT_EN.
module mriscv_lsu
`ifdef MRISCV_LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        legal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;

`ifdef MRISCV_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  // Request decode: legality, byte lanes and replicated store data
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b0000;
    wdata_c = lsu_data_i;
    case (lsu_size_i)
      3'b000, 3'b100: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << lsu_addr_i[1:0];
        wdata_c = {4{lsu_data_i[7:0]}};
      end
      3'b001, 3'b101: begin
        legal_c = ~lsu_addr_i[0];
        be_c    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_c = {2{lsu_data_i[15:0]}};
      end
      3'b010: begin
        legal_c = (lsu_addr_i[1:0] == 2'b00);
        be_c    = 4'b1111;
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Load alignment and sign/zero extension
  always_comb begin
    ld_byte_c = data_rdata_i[{off_q, 3'b000} +: 8];
    ld_half_c = data_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (size_q[1:0])
      2'b00:   ld_c = {{24{~size_q[2] & ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_c = {{16{~size_q[2] & ld_half_c[15]}}, ld_half_c};
      default: ld_c = data_rdata_i;
    endcase
  end

  assign lsu_err_o = (state_q == S_IDLE) & lsu_req_i & ~legal_c;

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    we_d            = we_q;
    be_d            = be_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    size_d          = size_q;
    off_d           = off_q;
    lsu_stall_req_o = 1'b0;
`ifdef MRISCV_LSU_TIMEOUT_EN
    cnt_d           = cnt_q;
    fault_d         = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i && legal_c) begin
          state_d         = S_WAIT;
          req_d           = 1'b1;
          we_d            = lsu_we_i;
          be_d            = be_c;
          addr_d          = {lsu_addr_i[31:2], 2'b00};
          wdata_d         = wdata_c;
          size_d          = lsu_size_i;
          off_d           = lsu_addr_i[1:0];
          lsu_stall_req_o = 1'b1;
`ifdef MRISCV_LSU_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      S_WAIT: begin
        lsu_stall_req_o = 1'b1;
        if (data_rvalid_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = ld_c;
        end
`ifdef MRISCV_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          rdata_d = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

`ifdef MRISCV_LSU_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign lsu_fault_o = fault_q;
`else
  assign lsu_fault_o = 1'b0;
`endif

  assign lsu_data_o   = rdata_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_mriscv_lsu.sv
// Directed self-checking bench for mriscv_lsu; expected values are hand-computed.
module tb_mriscv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'b000;
  logic [31:0] lsu_addr_i = '0, lsu_data_i = '0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_err_o, lsu_fault_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [31:0] data_rdata_i = '0;
  logic        data_rvalid_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

`ifdef MRISCV_LSU_TIMEOUT_EN
  mriscv_lsu #(.TIMEOUT_CYCLES(4)) u_dut (
`else
  mriscv_lsu u_dut (
`endif
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_err_o(lsu_err_o), .lsu_fault_o(lsu_fault_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One legal access: IDLE cycle, 1+dly WAIT cycles, DONE cycle; ends back in IDLE.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input logic [3:0] ebe, input logic [31:0] eaddr,
                        input logic [31:0] ewd, input logic [31:0] eld);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wd;
    #1;
    chk({tag, " idle stall"}, 32'(lsu_stall_req_o), 32'd1);
    chk({tag, " idle err"}, 32'(lsu_err_o), 32'd0);
    @(negedge clk_i);
    chk({tag, " req"}, 32'(data_req_o), 32'd1);
    chk({tag, " we"}, 32'(data_we_o), 32'(we));
    chk({tag, " be"}, 32'(data_be_o), 32'(ebe));
    chk({tag, " addr"}, data_addr_o, eaddr);
    chk({tag, " wdata"}, data_wdata_o, ewd);
    for (int i = 0; i < dly; i++) begin
      chk({tag, " wait stall"}, 32'(lsu_stall_req_o), 32'd1);
      @(negedge clk_i);
      chk({tag, " wait req"}, 32'(data_req_o), 32'd1);
      chk({tag, " wait addr"}, data_addr_o, eaddr);
    end
    chk({tag, " last wait stall"}, 32'(lsu_stall_req_o), 32'd1);
    data_rvalid_i = 1'b1; data_rdata_i = rd;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk({tag, " done stall"}, 32'(lsu_stall_req_o), 32'd0);
    chk({tag, " done req"}, 32'(data_req_o), 32'd0);
    chk({tag, " done data"}, lsu_data_o, eld);
    chk({tag, " done fault"}, 32'(lsu_fault_o), 32'd0);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic illegal(input string tag, input logic [2:0] size, input logic [31:0] addr);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = size; lsu_addr_i = addr;
    #1;
    chk({tag, " err"}, 32'(lsu_err_o), 32'd1);
    chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i);
    chk({tag, " no req"}, 32'(data_req_o), 32'd0);
    chk({tag, " still err"}, 32'(lsu_err_o), 32'd1);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    chk("rst req", 32'(data_req_o), 32'd0);
    chk("rst be", 32'(data_be_o), 32'd0);
    chk("rst addr", data_addr_o, 32'd0);
    chk("rst wdata", data_wdata_o, 32'd0);
    chk("rst data", lsu_data_o, 32'd0);
    chk("rst stall", 32'(lsu_stall_req_o), 32'd0);
    arstn_i = 1'b1;
    @(negedge clk_i);

    access("LW",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
    access("LB",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
    access("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'h100, 32'h0, 32'h00000080);
    access("SH",  1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h00000080);
    access("LH",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1, 4'b1100, 32'h100, 32'h0, 32'hFFFF80FF);
    access("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 4'b1100, 32'h100, 32'h0, 32'h000080FF);
    access("LHp", 1'b0, 3'b001, 32'h200, 32'h0, 32'h12347F80, 0, 4'b0011, 32'h200, 32'h0, 32'h00007F80);
    access("SB",  1'b1, 3'b000, 32'h301, 32'h0000005A, 32'hFFFFFFFF, 2, 4'b0010, 32'h300, 32'h5A5A5A5A, 32'h00007F80);
    access("SW",  1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 5, 4'b1111, 32'h104, 32'hCAFEF00D, 32'h00007F80);
    access("LBm", 1'b0, 3'b000, 32'h005, 32'h0, 32'h0000A500, 5, 4'b0010, 32'h004, 32'h0, 32'hFFFFFFA5);

    illegal("LWmis", 3'b010, 32'h102);
    illegal("LHmis", 3'b001, 32'h101);
    illegal("sz011", 3'b011, 32'h100);
    illegal("sz110", 3'b110, 32'h100);

    // rvalid while idle must not change anything
    data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("idle rvalid req", 32'(data_req_o), 32'd0);
    chk("idle rvalid data", lsu_data_o, 32'hFFFFFFA5);

    // Reset during WAIT aborts the access
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h400;
    @(negedge clk_i);
    chk("mid req", 32'(data_req_o), 32'd1);
    lsu_req_i = 1'b0;
    arstn_i = 1'b0;
    #1;
    chk("mid rst req", 32'(data_req_o), 32'd0);
    chk("mid rst stall", 32'(lsu_stall_req_o), 32'd0);
    chk("mid rst data", lsu_data_o, 32'd0);
    chk("mid rst addr", data_addr_o, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    access("LWpost", 1'b0, 3'b010, 32'h10, 32'h0, 32'h76543210, 0, 4'b1111, 32'h10, 32'h0, 32'h76543210);

`ifdef MRISCV_LSU_TIMEOUT_EN
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h500;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      chk("to wait req", 32'(data_req_o), 32'd1);
      chk("to wait fault", 32'(lsu_fault_o), 32'd0);
      @(negedge clk_i);
    end
    chk("to fault", 32'(lsu_fault_o), 32'd1);
    chk("to data", lsu_data_o, 32'd0);
    chk("to req", 32'(data_req_o), 32'd0);
    chk("to stall", 32'(lsu_stall_req_o), 32'd0);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("to fault pulse", 32'(lsu_fault_o), 32'd0);
`else
    chk("fault tied", 32'(lsu_fault_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
